// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: EX-stage event/CSR inputs and flush/redirect outputs.
`default_nettype none

interface trap_ctrl_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  int_cause;
  logic        mret;
  logic        ext_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        flush;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output ex_valid, ex_pc, int_cause, mret, ext_irq, csr_we, csr_addr, csr_wdata,
    input  csr_rdata, flush, stall, redirect, redirect_pc
  );

  modport slave (
    input  ex_valid, ex_pc, int_cause, mret, ext_irq, csr_we, csr_addr, csr_wdata,
    output csr_rdata, flush, stall, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl.sv
//------------------------------------------------------------------------------
// trap_ctrl : machine-mode trap CSRs and flush/drain/redirect sequencer.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt dispatch via mtvec.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trap_ctrl #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100
) (
  input  wire logic   clk,
  input  wire logic   rst,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [2:0]  c_drain_last = 3'(DRAIN_CYCLES - 1);
  localparam logic [11:0] c_mstatus    = 12'h300;
  localparam logic [11:0] c_mie        = 12'h304;
  localparam logic [11:0] c_mtvec      = 12'h305;
  localparam logic [11:0] c_mepc       = 12'h341;
  localparam logic [11:0] c_mcause     = 12'h342;
  localparam logic [11:0] c_mip        = 12'h344;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_mie, r_mpie, r_meie;
  logic [29:0] r_mtvec_base;
  logic [31:0] r_mepc, r_mcause, r_target;

  logic        w_idle, w_exc, w_irq, w_mret, w_accept, w_csr_wr, w_mode;
  logic [31:0] w_base, w_mtvec, w_target, w_cause;
  logic        w_flush, w_stall, w_redirect;
  logic [31:0] w_redirect_pc, w_rdata;

`ifdef TRAP_VECTORED_EN
  logic r_mtvec_mode;
  assign w_mode  = r_mtvec_mode;
  assign w_mtvec = {r_mtvec_base, 1'b0, r_mtvec_mode};
`else
  assign w_mode  = 1'b0;
  assign w_mtvec = {r_mtvec_base, 2'b00};
`endif

  assign w_idle   = (r_state == IDLE);
  assign w_exc    = bus.ex_valid & (bus.int_cause != 2'b00);
  assign w_irq    = bus.ex_valid & bus.ext_irq & r_mie & r_meie;
  assign w_mret   = bus.ex_valid & bus.mret;
  assign w_accept = w_idle & (w_exc | w_irq | w_mret);
  // An accepted event takes the cycle; a simultaneous CSR write is lost.
  assign w_csr_wr = bus.csr_we & w_idle & ~w_accept;
  assign w_base   = {r_mtvec_base, 2'b00};
  assign w_cause  = w_exc ? ((bus.int_cause == 2'b01) ? 32'd11 : 32'd2) : 32'h8000_000B;

  always_comb begin
    w_target = r_mepc;
    if (w_exc)
      w_target = w_base;
    else if (w_irq)
      w_target = w_mode ? (w_base + 32'd44) : w_base;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_flush       = 1'b0;
    w_stall       = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = 3'd0;
        end
      end
      DRAIN: begin
        w_flush = 1'b1;
        w_stall = 1'b1;
        if (r_cnt == c_drain_last)
          w_state_nxt = REDIRECT;
        else
          w_cnt_nxt = r_cnt + 3'd1;
      end
      REDIRECT: begin
        w_flush       = 1'b1;
        w_redirect    = 1'b1;
        w_redirect_pc = r_target;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie        <= 1'b0;
      r_mpie       <= 1'b0;
      r_meie       <= 1'b0;
      r_mtvec_base <= RESET_MTVEC[31:2];
`ifdef TRAP_VECTORED_EN
      r_mtvec_mode <= (RESET_MTVEC[1:0] == 2'b01);
`endif
      r_mepc       <= 32'd0;
      r_mcause     <= 32'd0;
      r_target     <= 32'd0;
    end else if (w_accept) begin
      r_target <= w_target;
      if (w_exc | w_irq) begin
        r_mepc   <= bus.ex_pc;
        r_mcause <= w_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end else if (w_csr_wr) begin
      case (bus.csr_addr)
        c_mstatus: begin
          r_mie  <= bus.csr_wdata[3];
          r_mpie <= bus.csr_wdata[7];
        end
        c_mie:    r_meie <= bus.csr_wdata[11];
        c_mtvec: begin
          r_mtvec_base <= bus.csr_wdata[31:2];
`ifdef TRAP_VECTORED_EN
          // Modes 1x are illegal and collapse to direct mode.
          r_mtvec_mode <= (bus.csr_wdata[1:0] == 2'b01);
`endif
        end
        c_mepc:   r_mepc   <= {bus.csr_wdata[31:2], 2'b00};
        c_mcause: r_mcause <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (bus.csr_addr)
      c_mstatus: w_rdata = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      c_mie:     w_rdata = {20'd0, r_meie, 11'd0};
      c_mip:     w_rdata = {20'd0, bus.ext_irq, 11'd0};
      c_mtvec:   w_rdata = w_mtvec;
      c_mepc:    w_rdata = r_mepc;
      c_mcause:  w_rdata = r_mcause;
      default:   w_rdata = 32'd0;
    endcase
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.flush       = w_flush;
  assign bus.stall       = w_stall;
  assign bus.redirect    = w_redirect;
  assign bus.redirect_pc = w_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic vs. a cycle-count model.
`default_nettype none

module tb_trap_ctrl;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_ctrl_if bus();

  trap_ctrl #(.DRAIN_CYCLES(D), .RESET_MTVEC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: seq==0 idle, 1..D drain, D+1 redirect.
  int          seq;
  logic [31:0] m_target, m_mtvec, m_mepc, m_mcause;
  bit          m_mie, m_mpie, m_meie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    seq = 0; m_target = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
    m_mie = 0; m_mpie = 0; m_meie = 0;
  endfunction

  function automatic logic [31:0] legal_mtvec(input logic [31:0] wd);
`ifdef TRAP_VECTORED_EN
    return {wd[31:2], 2'b00} | ((wd[1:0] == 2'b01) ? 32'd1 : 32'd0);
`else
    return {wd[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input bit irq);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return 32'(m_meie) << 11;
      12'h344: return 32'(irq) << 11;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input bit ev, input logic [1:0] ic, input logic [31:0] pc, input bit mr,
                      input bit irq, input bit we, input logic [11:0] addr, input logic [31:0] wd);
    bit exc, itr;
    @(negedge clk);
    bus.ex_valid = ev; bus.int_cause = ic; bus.ex_pc = pc; bus.mret = mr;
    bus.ext_irq = irq; bus.csr_we = we; bus.csr_addr = addr; bus.csr_wdata = wd;
    #1;
    check("flush", 32'(bus.flush), 32'(seq != 0));
    check("stall", 32'(bus.stall), 32'(seq >= 1 && seq <= D));
    check("redirect", 32'(bus.redirect), 32'(seq == D + 1));
    check("redirect_pc", bus.redirect_pc, (seq == D + 1) ? m_target : 32'd0);
    check("csr_rdata", bus.csr_rdata, model_read(addr, irq));
    if (seq != 0) begin
      seq = (seq == D + 1) ? 0 : seq + 1;
    end else begin
      exc = ev && (ic != 2'b00);
      itr = ev && irq && m_mie && m_meie;
      if (exc || itr) begin
        m_target = (!exc && m_mtvec[1:0] == 2'b01) ? {m_mtvec[31:2], 2'b00} + 32'd44
                                                   : {m_mtvec[31:2], 2'b00};
        m_mepc   = pc;
        m_mcause = exc ? ((ic == 2'b01) ? 32'd11 : 32'd2) : 32'h8000_000B;
        m_mpie   = m_mie;
        m_mie    = 0;
        seq      = 1;
      end else if (ev && mr) begin
        m_target = m_mepc;
        m_mie    = m_mpie;
        m_mpie   = 1;
        seq      = 1;
      end else if (we) begin
        case (addr)
          12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
          12'h304: m_meie = wd[11];
          12'h305: m_mtvec = legal_mtvec(wd);
          12'h341: m_mepc = wd & ~32'd3;
          12'h342: m_mcause = wd;
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 32'd0, 0, 0, 0, 12'h342, 32'd0);
  endtask

  task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_addr = addr;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h000, 12'h7FF};

  initial begin
    bus.ex_valid = 0; bus.int_cause = 0; bus.ex_pc = 0; bus.mret = 0;
    bus.ext_irq = 0; bus.csr_we = 0; bus.csr_addr = 12'h305; bus.csr_wdata = 0;
    rst = 1'b1;
    model_reset();
    #12;
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_redirect", 32'(bus.redirect), 32'd0);
    peek("rst_mtvec", 12'h305, 32'h100);
    @(negedge clk); rst = 1'b0;

    // ecall
    step(1, 2'b01, 32'h40, 0, 0, 0, 12'h341, 32'd0);
    idle(1);
    check("ecall_flush", 32'(bus.flush), 32'd1);
    peek("ecall_mepc", 12'h341, 32'h40);
    peek("ecall_mcause", 12'h342, 32'd11);
    peek("ecall_mstatus", 12'h300, 32'd0);
    idle(2);
    check("ecall_rpc", bus.redirect_pc, 32'h100);
    idle(1);

    // external interrupt
    step(0, 2'b00, 32'd0, 0, 0, 1, 12'h300, 32'h8);
    step(0, 2'b00, 32'd0, 0, 0, 1, 12'h304, 32'h800);
    step(1, 2'b00, 32'h80, 0, 1, 0, 12'h342, 32'd0);
    idle(1);
    peek("irq_mcause", 12'h342, 32'h8000_000B);
    peek("irq_mepc", 12'h341, 32'h80);
    peek("irq_mstatus", 12'h300, 32'h80);
    idle(2);
    check("irq_rpc", bus.redirect_pc, 32'h100);
    idle(1);

    // mret
    step(1, 2'b00, 32'h1234, 1, 0, 0, 12'h300, 32'd0);
    idle(1);
    peek("mret_mstatus", 12'h300, 32'h88);
    idle(2);
    check("mret_rpc", bus.redirect_pc, 32'h80);
    idle(1);

    // vectored interrupt
    step(0, 2'b00, 32'd0, 0, 0, 1, 12'h305, 32'h201);
    step(1, 2'b00, 32'h90, 0, 1, 0, 12'h305, 32'd0);
    idle(3);
`ifdef TRAP_VECTORED_EN
    check("vec_rpc", bus.redirect_pc, 32'h22C);
`else
    check("vec_rpc", bus.redirect_pc, 32'h200);
`endif
    idle(1);
    step(1, 2'b00, 32'd0, 1, 0, 0, 12'h300, 32'd0);
    idle(4);

    // simultaneous events and CSR write, then ignored ecall during drain
    step(1, 2'b10, 32'h300, 0, 1, 1, 12'h305, 32'h400);
    step(1, 2'b01, 32'h999, 0, 0, 0, 12'h341, 32'd0);
    peek("sim_mcause", 12'h342, 32'd2);
`ifdef TRAP_VECTORED_EN
    peek("sim_mtvec", 12'h305, 32'h201);
`else
    peek("sim_mtvec", 12'h305, 32'h200);
`endif
    peek("sim_mepc", 12'h341, 32'h300);
    idle(3);

    // reset in the first drain cycle
    step(1, 2'b01, 32'h500, 0, 0, 0, 12'h341, 32'd0);
    idle(1);
    rst = 1'b1;
    #1;
    check("rstmid_flush", 32'(bus.flush), 32'd0);
    check("rstmid_stall", 32'(bus.stall), 32'd0);
    check("rstmid_redirect", 32'(bus.redirect), 32'd0);
    peek("rstmid_mtvec", 12'h305, 32'h100);
    peek("rstmid_mepc", 12'h341, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    idle(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           addrs[$urandom_range(0, 7)],
           ($urandom_range(0, 3) == 0) ? 32'h0000_0888 : $urandom);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
